// File: rtl/tlb_mmu.sv
// Dual-port MMU: kseg0/kseg1 pass through, other segments use a
// fully-associative TLB with even/odd page pairs and ASID/global match.
module tlb_mmu #(
    parameter int TLB_ENTRIES  = 8,
    parameter int ASID_W       = 8,
    parameter int KSEG0_CACHED = 1,
    localparam int IDX_W       = $clog2(TLB_ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ASID_W-1:0] cur_asid,
    input  logic              inst_req,
    input  logic [31:0]       inst_vaddr,
    output logic              inst_valid,
    output logic [31:0]       inst_paddr,
    output logic              inst_cached,
    output logic              inst_miss,
    output logic              inst_inv,
    input  logic              data_req,
    input  logic [31:0]       data_vaddr,
    input  logic              data_wr,
    output logic              data_valid,
    output logic [31:0]       data_paddr,
    output logic              data_cached,
    output logic              data_miss,
    output logic              data_inv,
    output logic              data_mod,
    input  logic              tlb_we,
    input  logic [IDX_W-1:0]  tlb_windex,
    input  logic [18:0]       tlb_wvpn2,
    input  logic [ASID_W-1:0] tlb_wasid,
    input  logic              tlb_wg,
    input  logic [24:0]       tlb_wlo0,
    input  logic [24:0]       tlb_wlo1,
    input  logic              tlb_preq,
    output logic              tlb_phit,
    output logic [IDX_W-1:0]  tlb_pindex
);

    typedef struct packed {
        logic [18:0]       vpn2;
        logic [ASID_W-1:0] asid;
        logic              g;
        logic [24:0]       lo0;
        logic [24:0]       lo1;
    } tlb_entry_t;

    typedef struct packed {
        logic [31:0] paddr;
        logic        cached;
        logic        miss;
        logic        inv;
        logic        mod;
    } xlate_t;

    tlb_entry_t tlb [TLB_ENTRIES];

    xlate_t       inst_res;
    xlate_t       data_res;
    logic         probe_hit;
    logic [IDX_W-1:0] probe_idx;

    // Translate one address; scanning downward makes the lowest index win.
    function automatic xlate_t xlate(input logic [31:0] va,
                                     input logic [ASID_W-1:0] asid,
                                     input logic st);
        xlate_t r;
        logic hit;
        logic [24:0] lo;
        r = '0;
        hit = 1'b0;
        lo = '0;
        if (va[31:30] == 2'b10) begin
            r.paddr = {3'b000, va[28:0]};
            r.cached = ~va[29] & (KSEG0_CACHED != 0);
        end else begin
            for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
                if (tlb[i].vpn2 == va[31:13] &&
                    (tlb[i].g || tlb[i].asid == asid)) begin
                    hit = 1'b1;
                    lo = va[12] ? tlb[i].lo1 : tlb[i].lo0;
                end
            end
            if (!hit) begin
                r.miss = 1'b1;
            end else if (!lo[0]) begin
                r.inv = 1'b1;
            end else if (st && !lo[1]) begin
                r.mod = 1'b1;
            end else begin
                r.paddr = {lo[24:5], va[11:0]};
                r.cached = (lo[4:2] == 3'b011);
            end
        end
        return r;
    endfunction

    // Combinational lookups for both ports against current contents.
    always_comb begin
        inst_res = xlate(inst_vaddr, cur_asid, 1'b0);
        data_res = xlate(data_vaddr, cur_asid, data_wr);
    end

    // Probe match using the EntryHi key; lowest matching index wins.
    always_comb begin
        probe_hit = 1'b0;
        probe_idx = '0;
        for (int i = TLB_ENTRIES - 1; i >= 0; i--) begin
            if (tlb[i].vpn2 == tlb_wvpn2 &&
                (tlb[i].g || tlb[i].asid == tlb_wasid)) begin
                probe_hit = 1'b1;
                probe_idx = IDX_W'(i);
            end
        end
    end

    // TLB array: cleared on reset, one entry written per cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < TLB_ENTRIES; i++) begin
                tlb[i] <= '0;
            end
        end else if (tlb_we) begin
            tlb[tlb_windex] <= '{vpn2: tlb_wvpn2, asid: tlb_wasid,
                                 g: tlb_wg, lo0: tlb_wlo0, lo1: tlb_wlo1};
        end
    end

    // Inst result register; outputs hold while no request.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_valid  <= 1'b0;
            inst_paddr  <= '0;
            inst_cached <= 1'b0;
            inst_miss   <= 1'b0;
            inst_inv    <= 1'b0;
        end else begin
            inst_valid <= inst_req;
            if (inst_req) begin
                inst_paddr  <= inst_res.paddr;
                inst_cached <= inst_res.cached;
                inst_miss   <= inst_res.miss;
                inst_inv    <= inst_res.inv;
            end
        end
    end

    // Data result register; outputs hold while no request.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_valid  <= 1'b0;
            data_paddr  <= '0;
            data_cached <= 1'b0;
            data_miss   <= 1'b0;
            data_inv    <= 1'b0;
            data_mod    <= 1'b0;
        end else begin
            data_valid <= data_req;
            if (data_req) begin
                data_paddr  <= data_res.paddr;
                data_cached <= data_res.cached;
                data_miss   <= data_res.miss;
                data_inv    <= data_res.inv;
                data_mod    <= data_res.mod;
            end
        end
    end

    // Probe result register; held while no probe request.
    always_ff @(posedge clk) begin
        if (rst) begin
            tlb_phit   <= 1'b0;
            tlb_pindex <= '0;
        end else if (tlb_preq) begin
            tlb_phit   <= probe_hit;
            tlb_pindex <= probe_idx;
        end
    end

endmodule

// File: tb/tb_tlb_mmu.sv
// Directed bench for tlb_mmu: unmapped segments, TLB hit/miss/inv/mod,
// write/lookup ordering, duplicate-entry priority, probe and reset.
module tb_tlb_mmu;

    logic        clk;
    logic        rst;
    logic [7:0]  cur_asid;
    logic        inst_req;
    logic [31:0] inst_vaddr;
    logic        inst_valid;
    logic [31:0] inst_paddr;
    logic        inst_cached;
    logic        inst_miss;
    logic        inst_inv;
    logic        data_req;
    logic [31:0] data_vaddr;
    logic        data_wr;
    logic        data_valid;
    logic [31:0] data_paddr;
    logic        data_cached;
    logic        data_miss;
    logic        data_inv;
    logic        data_mod;
    logic        tlb_we;
    logic [2:0]  tlb_windex;
    logic [18:0] tlb_wvpn2;
    logic [7:0]  tlb_wasid;
    logic        tlb_wg;
    logic [24:0] tlb_wlo0;
    logic [24:0] tlb_wlo1;
    logic        tlb_preq;
    logic        tlb_phit;
    logic [2:0]  tlb_pindex;

    int nvec = 0;
    int nerr = 0;

    tlb_mmu dut (
        .clk(clk), .rst(rst), .cur_asid(cur_asid),
        .inst_req(inst_req), .inst_vaddr(inst_vaddr),
        .inst_valid(inst_valid), .inst_paddr(inst_paddr),
        .inst_cached(inst_cached), .inst_miss(inst_miss),
        .inst_inv(inst_inv),
        .data_req(data_req), .data_vaddr(data_vaddr),
        .data_wr(data_wr), .data_valid(data_valid),
        .data_paddr(data_paddr), .data_cached(data_cached),
        .data_miss(data_miss), .data_inv(data_inv),
        .data_mod(data_mod),
        .tlb_we(tlb_we), .tlb_windex(tlb_windex),
        .tlb_wvpn2(tlb_wvpn2), .tlb_wasid(tlb_wasid),
        .tlb_wg(tlb_wg), .tlb_wlo0(tlb_wlo0), .tlb_wlo1(tlb_wlo1),
        .tlb_preq(tlb_preq), .tlb_phit(tlb_phit),
        .tlb_pindex(tlb_pindex)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [24:0] lo(input logic [19:0] pfn,
                                       input logic [2:0] c,
                                       input logic d, input logic v);
        return {pfn, c, d, v};
    endfunction

    task automatic wr_entry(input logic [2:0] idx, input logic [18:0] vpn2,
                            input logic [7:0] asid, input logic g,
                            input logic [24:0] l0, input logic [24:0] l1);
        @(negedge clk);
        tlb_we = 1'b1;
        tlb_windex = idx;
        tlb_wvpn2 = vpn2;
        tlb_wasid = asid;
        tlb_wg = g;
        tlb_wlo0 = l0;
        tlb_wlo1 = l1;
        @(posedge clk);
        #1;
        tlb_we = 1'b0;
    endtask

    task automatic ilook(input logic [31:0] va);
        @(negedge clk);
        inst_req = 1'b1;
        inst_vaddr = va;
        @(posedge clk);
        #1;
        inst_req = 1'b0;
    endtask

    task automatic dlook(input logic [31:0] va, input logic st);
        @(negedge clk);
        data_req = 1'b1;
        data_vaddr = va;
        data_wr = st;
        @(posedge clk);
        #1;
        data_req = 1'b0;
        data_wr = 1'b0;
    endtask

    task automatic probe(input logic [18:0] vpn2, input logic [7:0] asid);
        @(negedge clk);
        tlb_preq = 1'b1;
        tlb_wvpn2 = vpn2;
        tlb_wasid = asid;
        @(posedge clk);
        #1;
        tlb_preq = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        cur_asid = 8'd0;
        inst_req = 1'b0;
        inst_vaddr = '0;
        data_req = 1'b0;
        data_vaddr = '0;
        data_wr = 1'b0;
        tlb_we = 1'b0;
        tlb_windex = '0;
        tlb_wvpn2 = '0;
        tlb_wasid = '0;
        tlb_wg = 1'b0;
        tlb_wlo0 = '0;
        tlb_wlo1 = '0;
        tlb_preq = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        chk("rst_ivalid", 32'(inst_valid), 32'd0);
        chk("rst_ipaddr", inst_paddr, 32'd0);
        chk("rst_dvalid", 32'(data_valid), 32'd0);
        chk("rst_phit", 32'(tlb_phit), 32'd0);

        ilook(32'hBFC00000);
        chk("kseg1_valid", 32'(inst_valid), 32'd1);
        chk("kseg1_paddr", inst_paddr, 32'h1FC00000);
        chk("kseg1_cached", 32'(inst_cached), 32'd0);
        chk("kseg1_miss", 32'(inst_miss), 32'd0);
        @(posedge clk);
        #1;
        chk("ivalid_drop", 32'(inst_valid), 32'd0);
        chk("ipaddr_hold", inst_paddr, 32'h1FC00000);

        dlook(32'h80001234, 1'b0);
        chk("kseg0_valid", 32'(data_valid), 32'd1);
        chk("kseg0_paddr", data_paddr, 32'h00001234);
        chk("kseg0_cached", 32'(data_cached), 32'd1);

        dlook(32'hA0000010, 1'b1);
        chk("kseg1d_paddr", data_paddr, 32'h00000010);
        chk("kseg1d_cached", 32'(data_cached), 32'd0);
        chk("kseg1d_mod", 32'(data_mod), 32'd0);

        dlook(32'h00400000, 1'b0);
        chk("empty_miss", 32'(data_miss), 32'd1);
        chk("empty_paddr", data_paddr, 32'd0);
        chk("empty_cached", 32'(data_cached), 32'd0);

        cur_asid = 8'd5;
        wr_entry(3'd3, 19'h00200, 8'd5, 1'b0,
                 lo(20'h12345, 3'd3, 1'b1, 1'b1),
                 lo(20'h0ABCD, 3'd3, 1'b0, 1'b0));
        dlook(32'h00400ABC, 1'b0);
        chk("hit_paddr", data_paddr, 32'h12345ABC);
        chk("hit_cached", 32'(data_cached), 32'd1);
        chk("hit_miss", 32'(data_miss), 32'd0);

        ilook(32'h00400ABC);
        chk("ihit_paddr", inst_paddr, 32'h12345ABC);

        cur_asid = 8'd6;
        ilook(32'h00400ABC);
        chk("asid_miss", 32'(inst_miss), 32'd1);
        chk("asid_paddr", inst_paddr, 32'd0);
        cur_asid = 8'd5;

        dlook(32'h00402000, 1'b0);
        chk("pair_edge_miss", 32'(data_miss), 32'd1);

        ilook(32'h00401000);
        chk("odd_inv", 32'(inst_inv), 32'd1);
        chk("odd_inv_miss", 32'(inst_miss), 32'd0);
        chk("odd_inv_paddr", inst_paddr, 32'd0);

        wr_entry(3'd3, 19'h00200, 8'd5, 1'b0,
                 lo(20'h12345, 3'd3, 1'b1, 1'b1),
                 lo(20'h0ABCD, 3'd2, 1'b0, 1'b1));
        dlook(32'h00401010, 1'b1);
        chk("mod_flag", 32'(data_mod), 32'd1);
        chk("mod_paddr", data_paddr, 32'd0);
        chk("mod_inv", 32'(data_inv), 32'd0);
        dlook(32'h00401010, 1'b0);
        chk("load_mod", 32'(data_mod), 32'd0);
        chk("load_paddr", data_paddr, 32'h0ABCD010);
        chk("load_cached", 32'(data_cached), 32'd0);
        ilook(32'h00401010);
        chk("inst_nomod", 32'(inst_inv), 32'd0);

        @(negedge clk);
        tlb_we = 1'b1;
        tlb_windex = 3'd3;
        tlb_wvpn2 = 19'h00200;
        tlb_wasid = 8'd5;
        tlb_wg = 1'b0;
        tlb_wlo0 = lo(20'h54321, 3'd3, 1'b1, 1'b1);
        tlb_wlo1 = lo(20'h0ABCD, 3'd2, 1'b0, 1'b1);
        inst_req = 1'b1;
        inst_vaddr = 32'h00400ABC;
        @(posedge clk);
        #1;
        tlb_we = 1'b0;
        inst_req = 1'b0;
        chk("same_cyc_old", inst_paddr, 32'h12345ABC);
        ilook(32'h00400ABC);
        chk("next_cyc_new", inst_paddr, 32'h54321ABC);

        cur_asid = 8'd9;
        wr_entry(3'd5, 19'h00300, 8'd9, 1'b0,
                 lo(20'h55555, 3'd3, 1'b1, 1'b1), '0);
        wr_entry(3'd1, 19'h00300, 8'd0, 1'b1,
                 lo(20'h11111, 3'd3, 1'b1, 1'b1), '0);
        dlook(32'h00600123, 1'b1);
        chk("dup_low_idx", data_paddr, 32'h11111123);
        probe(19'h00300, 8'd9);
        chk("probe_hit", 32'(tlb_phit), 32'd1);
        chk("probe_idx", 32'(tlb_pindex), 32'd1);
        probe(19'h00200, 8'd5);
        chk("probe3_idx", 32'(tlb_pindex), 32'd3);
        probe(19'h00200, 8'd7);
        chk("probe_miss", 32'(tlb_phit), 32'd0);
        chk("probe_miss_idx", 32'(tlb_pindex), 32'd0);

        dlook(32'hC0000000, 1'b0);
        chk("kseg2_miss", 32'(data_miss), 32'd1);

        @(negedge clk);
        rst = 1'b1;
        inst_req = 1'b1;
        inst_vaddr = 32'h80000040;
        @(posedge clk);
        #1;
        rst = 1'b0;
        inst_req = 1'b0;
        chk("rst_mid_valid", 32'(inst_valid), 32'd0);
        chk("rst_mid_paddr", inst_paddr, 32'd0);
        cur_asid = 8'd5;
        ilook(32'h00400ABC);
        chk("rst_clr_tlb", 32'(inst_miss), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
